// File: rtl/grass_pixel_fetch.sv
// Consumer end of the grass address interface: ROM addressing, read-latency realignment,
// writable 16-entry palette lookup and a per-frame opaque-pixel counter.
module grass_pixel_fetch #(
    parameter int unsigned ROM_LAT    = 2,
    parameter int unsigned IMG_WORDS  = 149760,
    parameter logic [3:0]  TRANSP_IDX = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        is_grass,
    input  logic [17:0] grass_addr,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_waddr,
    input  logic [23:0] pal_wdata,
    output logic        grass_on,
    output logic [23:0] grass_rgb,
    output logic [17:0] frame_count
);

    localparam logic [17:0] IMG_LIMIT = 18'(IMG_WORDS);
    localparam logic [17:0] CNT_MAX   = '1;

    logic        in_image;
    logic        v0;
    logic        v_sr [ROM_LAT];
    logic        v_last;

    logic [23:0] palette [16];
    logic [23:0] pal_entry;
    logic        on_next;
    logic [23:0] rgb_next;

    logic        frame_clk_q;
    logic        frame_rise;
    logic [17:0] running;
    logic [17:0] run_next;

    // Off-image addresses are squashed here so they never reach the ROM.
    assign in_image = is_grass && (grass_addr < IMG_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order of statements or processes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            v0       <= 1'b0;
        end else begin
            rom_addr <= in_image ? grass_addr : '0;
            v0       <= in_image;
        end
    end

    // Valid bit travels alongside the ROM access so it lines up with rom_data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(ROM_LAT); i++) v_sr[i] <= 1'b0;
        end else begin
            v_sr[0] <= v0;
            for (int i = 1; i < int'(ROM_LAT); i++) v_sr[i] <= v_sr[i-1];
        end
    end

    assign v_last = v_sr[ROM_LAT-1];

    // NOTE: every always_comb output gets a default first, so no path can leave a
    // value held over from a previous evaluation (which would infer a latch).
    always_comb begin
        on_next   = v_last && (rom_data != TRANSP_IDX);
        pal_entry = palette[rom_data];
        if (pal_we && (pal_waddr == rom_data)) pal_entry = pal_wdata;
        rgb_next  = on_next ? pal_entry : 24'h0;
    end

    // NOTE: the palette is small and needs a known grey-ramp default, so unlike a
    // bulk RAM it is built from flops that are reset explicitly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) palette[i] <= {3{4'(i), 4'h0}};
        end else if (pal_we) begin
            palette[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grass_on  <= 1'b0;
            grass_rgb <= '0;
        end else begin
            grass_on  <= on_next;
            grass_rgb <= rgb_next;
        end
    end

    // The edge cycle's own pixel is credited to the frame that is closing.
    assign frame_rise = frame_clk && !frame_clk_q;
    assign run_next   = (grass_on && (running != CNT_MAX)) ? running + 18'd1 : running;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            running     <= '0;
            frame_count <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            if (frame_rise) begin
                frame_count <= run_next;
                running     <= '0;
            end else begin
                running     <= run_next;
            end
        end
    end

endmodule

// File: tb/tb_grass_pixel_fetch.sv
// Directed bench for grass_pixel_fetch: vector table for the pixel stream plus hand-written
// sequences for reset, palette write-through and frame counting.
module tb_grass_pixel_fetch;

    localparam int LAT = 2;
    localparam int PIPE = LAT + 2;
    localparam int N_VEC = 20;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        is_grass;
    logic [17:0] grass_addr;
    logic [17:0] rom_addr;
    logic [3:0]  rom_data;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic        grass_on;
    logic [23:0] grass_rgb;
    logic [17:0] frame_count;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        is_grass;
        logic [17:0] addr;
        logic [17:0] exp_rom;
        logic        exp_on;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs [N_VEC];

    grass_pixel_fetch #(.ROM_LAT(LAT), .IMG_WORDS(149760), .TRANSP_IDX(4'h0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .is_grass    (is_grass),
        .grass_addr  (grass_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pal_we      (pal_we),
        .pal_waddr   (pal_waddr),
        .pal_wdata   (pal_wdata),
        .grass_on    (grass_on),
        .grass_rgb   (grass_rgb),
        .frame_count (frame_count)
    );

    always #5 Clk = ~Clk;

    // ROM model: index = low address nibble, LAT cycles after rom_addr.
    logic [3:0] rom_pipe [LAT];
    always @(posedge Clk) begin
        rom_pipe[0] <= rom_addr[3:0];
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic [17:0] a);
        is_grass   = g;
        grass_addr = a;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].is_grass = 1'b1;
            vecs[i].addr     = 18'(i);
            vecs[i].exp_rom  = 18'(i);
            vecs[i].exp_on   = (i != 0);
            vecs[i].exp_rgb  = (i != 0) ? {3{4'(i), 4'h0}} : 24'h0;
        end
        vecs[16] = '{1'b1, 18'd149760,  18'd0,      1'b0, 24'h000000};
        vecs[17] = '{1'b1, 18'h3FFFF,   18'd0,      1'b0, 24'h000000};
        vecs[18] = '{1'b1, 18'd149759,  18'd149759, 1'b1, 24'hF0F0F0};
        vecs[19] = '{1'b0, 18'd5,       18'd0,      1'b0, 24'h000000};

        // Reset held with inputs active
        Reset = 1'b1;
        frame_clk = 1'b0;
        pal_we = 1'b0;
        pal_waddr = '0;
        pal_wdata = '0;
        drive(1'b1, 18'd3);
        repeat (3) tick();
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_on", 32'(grass_on), 32'd0);
        check("rst_rgb", 32'(grass_rgb), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        Reset = 1'b0;
        check("post_rst_on_0", 32'(grass_on), 32'd0);
        for (int c = 1; c < PIPE; c++) begin
            tick();
            check("post_rst_on", 32'(grass_on), 32'd0);
            check("post_rst_rgb", 32'(grass_rgb), 32'd0);
        end
        tick();
        check("first_on", 32'(grass_on), 32'd1);
        check("first_rgb", 32'(grass_rgb), 32'h303030);

        // Vector table: grey ramp and off-image addresses
        for (int j = 0; j < N_VEC + PIPE; j++) begin
            tick();
            if (j >= PIPE) begin
                check("vec_on", 32'(grass_on), 32'(vecs[j-PIPE].exp_on));
                check("vec_rgb", 32'(grass_rgb), 32'(vecs[j-PIPE].exp_rgb));
            end
            if (j >= 1 && j - 1 < N_VEC)
                check("vec_rom_addr", 32'(rom_addr), 32'(vecs[j-1].exp_rom));
            if (j < N_VEC) drive(vecs[j].is_grass, vecs[j].addr);
            else drive(1'b0, 18'd0);
        end

        // Palette write in the same cycle as lookup of that entry
        tick(); drive(1'b1, 18'd5);
        tick(); drive(1'b0, 18'd0);
        tick();
        tick(); pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 24'h00FF00;
        tick(); pal_we = 1'b0;
        check("bypass_on", 32'(grass_on), 32'd1);
        check("bypass_rgb", 32'(grass_rgb), 32'h00FF00);
        tick(); drive(1'b1, 18'd5);
        tick(); drive(1'b1, 18'd6);
        tick(); drive(1'b0, 18'd0);
        tick();
        tick();
        check("stored_rgb5", 32'(grass_rgb), 32'h00FF00);
        tick();
        check("neighbour_rgb6", 32'(grass_rgb), 32'h606060);
        repeat (3) tick();

        // Frame counting: 100 opaque pixels, then an empty frame
        frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 18'd1);
            tick();
        end
        drive(1'b0, 18'd0);
        repeat (6) tick();
        frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
        check("frame_100", 32'(frame_count), 32'd100);
        repeat (5) tick();
        frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
        check("frame_empty", 32'(frame_count), 32'd0);

        // Frame edge while pixels are in flight
        repeat (2) tick();
        drive(1'b1, 18'd2);
        tick();
        tick(); drive(1'b0, 18'd0);
        tick();
        tick();
        frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
        check("edge_old_frame", 32'(frame_count), 32'd1);
        repeat (6) tick();
        frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
        check("edge_new_frame", 32'(frame_count), 32'd1);

        // Reset mid-stream
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 18'd7);
            tick();
        end
        Reset = 1'b1;
        #1;
        check("mid_rst_on", 32'(grass_on), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        tick();
        Reset = 1'b0;
        drive(1'b0, 18'd0);
        for (int c = 0; c < PIPE + 2; c++) begin
            tick();
            check("flush_on", 32'(grass_on), 32'd0);
            check("flush_rgb", 32'(grass_rgb), 32'd0);
        end
        check("flush_frame_count", 32'(frame_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
